// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock time keeper: state encoding,
// HHMM widths and limits, and small BCD helpers.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } state_t;

    localparam int          BCD_HHMM         = 16;
    localparam logic [15:0] MIDNIGHT         = 16'h0000;
    localparam logic [15:0] ALARM_RESET_TIME = 16'h0600;
    localparam logic [7:0]  MAX_HOUR         = 8'h23;
    localparam logic [7:0]  MAX_MIN          = 8'h59;

    // Two-digit BCD increment without wrap; callers handle their own limit.
    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Binary (0..99) to two-digit BCD, used for elaboration-time constants.
    function automatic logic [7:0] to_bcd8(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/time_keeper_if.sv
// User controls in, display/alarm values out of the time keeper.
interface time_keeper_if;
    import clock_pkg::*;

    logic                set_time;
    logic                set_alarm;
    logic                inc_hour;
    logic                inc_min;
    logic [BCD_HHMM-1:0] current_time;
    logic [BCD_HHMM-1:0] alarm_time;
    logic                show_alarm;
    logic [7:0]          seconds;
    logic                one_minute;

    modport slave (
        input  set_time, set_alarm, inc_hour, inc_min,
        output current_time, alarm_time, show_alarm, seconds, one_minute
    );

    modport master (
        output set_time, set_alarm, inc_hour, inc_min,
        input  current_time, alarm_time, show_alarm, seconds, one_minute
    );

endinterface

// File: rtl/bcd_hhmm_inc.sv
// Combinational next-value logic for a BCD HHMM register. Minute wrap
// carries into the hour only when carry_en is set (normal timekeeping);
// the set modes adjust minutes and hours independently.
module bcd_hhmm_inc
    import clock_pkg::*;
(
    input  logic [BCD_HHMM-1:0] hhmm,
    input  logic                inc_min,
    input  logic                inc_hour,
    input  logic                carry_en,
    output logic [BCD_HHMM-1:0] next_hhmm
);

    logic [7:0] hour;
    logic [7:0] minute;
    logic       min_wrap;
    logic       hour_step;

    // Minute step first, then hour step from either button or carry.
    always_comb begin
        hour      = hhmm[15:8];
        minute    = hhmm[7:0];
        min_wrap  = 1'b0;
        hour_step = inc_hour;

        if (inc_min) begin
            if (minute == MAX_MIN) begin
                minute   = 8'h00;
                min_wrap = 1'b1;
            end else begin
                minute = bcd_inc8(minute);
            end
        end

        if (carry_en && min_wrap)
            hour_step = 1'b1;

        if (hour_step)
            hour = (hour == MAX_HOUR) ? 8'h00 : bcd_inc8(hour);

        next_hhmm = {hour, minute};
    end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day source: prescaler -> BCD seconds -> BCD HHMM, with
// time-set and alarm-set modes driven by hour/minute buttons.
module time_keeper
    import clock_pkg::*;
#(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int SECS_PER_MIN = 60
) (
    input  logic          clk,
    input  logic          reset,
    time_keeper_if.slave  bus
);

    localparam int             PW       = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(CLKS_PER_SEC - 1);
    localparam logic [7:0]     SEC_LAST = to_bcd8(SECS_PER_MIN - 1);

    state_t              state;
    state_t              state_next;
    logic                in_set_time;
    logic                in_set_alarm;

    logic [PW-1:0]       prescaler;
    logic [7:0]          seconds;
    logic [BCD_HHMM-1:0] current_time;
    logic [BCD_HHMM-1:0] alarm_time;
    logic                one_minute;

    logic                sec_tick;
    logic                min_tick;
    logic [BCD_HHMM-1:0] cur_next;
    logic [BCD_HHMM-1:0] alm_next;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    // Mode select (set_time wins) and decodes of the registered state.
    always_comb begin
        state_next   = RUN;
        in_set_time  = 1'b0;
        in_set_alarm = 1'b0;
        if (bus.set_time)
            state_next = SET_TIME;
        else if (bus.set_alarm)
            state_next = SET_ALARM;
        case (state)
            SET_TIME:  in_set_time  = 1'b1;
            SET_ALARM: in_set_alarm = 1'b1;
            default:   ;
        endcase
    end

    // Timekeeping is frozen while setting the time, so ticks only occur outside it.
    assign sec_tick = !in_set_time && (prescaler == PRE_LAST);
    assign min_tick = sec_tick && (seconds == SEC_LAST);

    // Prescaler: held at zero in time-set so the first second after leaving is full length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prescaler <= '0;
        else if (in_set_time || sec_tick)
            prescaler <= '0;
        else
            prescaler <= prescaler + PW'(1);
    end

    // BCD seconds counter, wrapping at the minute boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            seconds <= 8'h00;
        else if (in_set_time || min_tick)
            seconds <= 8'h00;
        else if (sec_tick)
            seconds <= bcd_inc8(seconds);
    end

    // Current time: minute ticks with full carry, or button edits without carry.
    bcd_hhmm_inc u_cur_inc (
        .hhmm      (current_time),
        .inc_min   (in_set_time ? bus.inc_min : min_tick),
        .inc_hour  (in_set_time & bus.inc_hour),
        .carry_en  (!in_set_time),
        .next_hhmm (cur_next)
    );

    // Alarm time: button edits only, only while in alarm-set.
    bcd_hhmm_inc u_alm_inc (
        .hhmm      (alarm_time),
        .inc_min   (in_set_alarm & bus.inc_min),
        .inc_hour  (in_set_alarm & bus.inc_hour),
        .carry_en  (1'b0),
        .next_hhmm (alm_next)
    );

    // Output registers; one_minute lines up with the first cycle of the new time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_time <= MIDNIGHT;
            alarm_time   <= ALARM_RESET_TIME;
            one_minute   <= 1'b0;
        end else begin
            current_time <= cur_next;
            alarm_time   <= alm_next;
            one_minute   <= min_tick;
        end
    end

    assign bus.current_time = current_time;
    assign bus.alarm_time   = alarm_time;
    assign bus.seconds      = seconds;
    assign bus.one_minute   = one_minute;
    assign bus.show_alarm   = in_set_alarm;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios plus a random phase, all
// checked every cycle against an integer minutes-of-day reference model.
module tb_time_keeper;

    localparam int CPS = 2;
    localparam int SPM = 3;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   ones = 0;

    // Reference model state in plain integers.
    int m_mode, m_pre, m_sec, m_tod, m_alarm, m_one;

    time_keeper_if tkif ();

    time_keeper #(.CLKS_PER_SEC(CPS), .SECS_PER_MIN(SPM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tkif)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_hhmm(input int t);
        int h, m;
        h = t / 60;
        m = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic int inc_hm(input int t, input bit im, input bit ih);
        int h, m;
        h = t / 60;
        m = t % 60;
        if (im) m = (m + 1) % 60;
        if (ih) h = (h + 1) % 24;
        return h * 60 + m;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pre = 0; m_sec = 0; m_tod = 0; m_alarm = 6 * 60; m_one = 0;
    endtask

    // One clock edge of the reference, using the inputs present at that edge.
    task automatic model_step();
        m_one = 0;
        if (m_mode == 1) begin
            m_pre = 0;
            m_sec = 0;
            m_tod = inc_hm(m_tod, tkif.inc_min, tkif.inc_hour);
        end else begin
            m_pre++;
            if (m_pre == CPS) begin
                m_pre = 0;
                m_sec++;
                if (m_sec == SPM) begin
                    m_sec = 0;
                    m_tod = (m_tod + 1) % 1440;
                    m_one = 1;
                end
            end
            if (m_mode == 2)
                m_alarm = inc_hm(m_alarm, tkif.inc_min, tkif.inc_hour);
        end
        m_mode = tkif.set_time ? 1 : (tkif.set_alarm ? 2 : 0);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("current_time", tkif.current_time, to_hhmm(m_tod));
        check("alarm_time",   tkif.alarm_time,   to_hhmm(m_alarm));
        check("seconds",      {8'h00, tkif.seconds}, {8'h00, 4'(m_sec / 10), 4'(m_sec % 10)});
        check("show_alarm",   {15'd0, tkif.show_alarm}, (m_mode == 2) ? 16'd1 : 16'd0);
        check("one_minute",   {15'd0, tkif.one_minute}, 16'(m_one));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (tkif.one_minute === 1'b1) ones++;
    endtask

    task automatic pulse_min();
        tkif.inc_min = 1'b1; step(); tkif.inc_min = 1'b0;
    endtask

    task automatic pulse_hour();
        tkif.inc_hour = 1'b1; step(); tkif.inc_hour = 1'b0;
    endtask

    task automatic hold_reset_release();
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tkif.set_time = 1'b0; tkif.set_alarm = 1'b0;
        tkif.inc_hour = 1'b0; tkif.inc_min = 1'b0;
        hold_reset_release();

        // 1: idle run from reset reaches 00:01 after one minute of ticks.
        ones = 0;
        repeat (6) step();
        check("t1_time", tkif.current_time, 16'h0001);
        check("t1_one_minute_count", 16'(ones), 16'd1);
        check("t1_seconds", {8'h00, tkif.seconds}, 16'h0000);
        check("t1_alarm", tkif.alarm_time, 16'h0600);

        // 2: set 23:59, release, rollover to midnight.
        tkif.set_time = 1'b1; step();
        repeat (23) pulse_hour();
        repeat (58) pulse_min();
        check("t2_set", tkif.current_time, 16'h2359);
        tkif.set_time = 1'b0; step();
        ones = 0;
        repeat (6) step();
        check("t2_midnight", tkif.current_time, 16'h0000);
        check("t2_one_minute_count", 16'(ones), 16'd1);

        // 3: minute wrap without hour carry, hour wrap keeps minutes.
        tkif.set_time = 1'b1; step();
        repeat (12) pulse_hour();
        repeat (59) pulse_min();
        check("t3_1259", tkif.current_time, 16'h1259);
        pulse_min();
        check("t3_min_wrap", tkif.current_time, 16'h1200);
        repeat (11) pulse_hour();
        pulse_min(); pulse_min(); pulse_min();
        check("t3_2303", tkif.current_time, 16'h2303);
        pulse_hour();
        check("t3_hour_wrap", tkif.current_time, 16'h0003);
        repeat (57) pulse_min();
        check("t3_back_0000", tkif.current_time, 16'h0000);

        // 4: alarm-set with both buttons in one cycle; time keeps running.
        tkif.set_time = 1'b0; tkif.set_alarm = 1'b1; step();
        tkif.inc_hour = 1'b1; tkif.inc_min = 1'b1; step();
        tkif.inc_hour = 1'b0; tkif.inc_min = 1'b0;
        check("t4_alarm", tkif.alarm_time, 16'h0701);
        check("t4_show", {15'd0, tkif.show_alarm}, 16'd1);
        repeat (8) step();
        check("t4_ticking", tkif.current_time, 16'h0001);
        check("t4_show_held", {15'd0, tkif.show_alarm}, 16'd1);

        // 5: both modes requested -> time-set wins.
        tkif.set_time = 1'b1; step();
        pulse_min();
        check("t5_time", tkif.current_time, 16'h0002);
        check("t5_alarm", tkif.alarm_time, 16'h0701);
        check("t5_show", {15'd0, tkif.show_alarm}, 16'd0);

        // 6: async reset in the middle of alarm-set at 09:45.
        tkif.set_time = 1'b0; step();
        repeat (2) pulse_hour();
        repeat (44) pulse_min();
        check("t6_alarm", tkif.alarm_time, 16'h0945);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_time", tkif.current_time, 16'h0000);
        check("t6_rst_alarm", tkif.alarm_time, 16'h0600);
        check("t6_rst_sec", {8'h00, tkif.seconds}, 16'h0000);
        check("t6_rst_one", {15'd0, tkif.one_minute}, 16'd0);
        check("t6_rst_show", {15'd0, tkif.show_alarm}, 16'd0);
        tkif.set_alarm = 1'b0;
        hold_reset_release();
        step();
        check("t6_run_show", {15'd0, tkif.show_alarm}, 16'd0);

        // Random phase: mode held for short spans, sparse button pulses.
        for (int blk = 0; blk < 40; blk++) begin
            int sel;
            sel = int'($urandom_range(0, 5));
            tkif.set_time  = (sel == 1) || (sel == 3);
            tkif.set_alarm = (sel == 2) || (sel == 3);
            for (int c = 0; c < 15; c++) begin
                tkif.inc_min  = ($urandom_range(0, 2) == 0);
                tkif.inc_hour = ($urandom_range(0, 3) == 0);
                step();
            end
            tkif.inc_min = 1'b0; tkif.inc_hour = 1'b0;
        end
        tkif.set_time = 1'b0; tkif.set_alarm = 1'b0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
